// File: rtl/dmem_lsu_pkg.sv
// Shared memory-access constants and the LSU state type for the RV32I Memory stage.
// Used by dmem_lsu (LSU_MISALIGN_TRAP_EN selects trap vs. force-align) and load_extend.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Unlisted encodings (011, 110, 111) fall through to word size.
  function automatic logic [1:0] access_size(input logic [2:0] funct3);
    if (funct3[1])      return SZ_WORD;
    else if (funct3[0]) return SZ_HALF;
    else                return SZ_BYTE;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Data-memory bus between the LSU (master) and the data memory (slave).
interface dmem_if;
  // Handshake: the master raises DMemReq with DMemWe/DMemAddr/DMemWData/DMemWStrb
  // and keeps them stable until a cycle in which DMemReady is high; that cycle
  // completes the transfer and DMemRData is valid in it for reads.
  logic        DMemReq;
  logic        DMemWe;
  logic [31:0] DMemAddr;
  logic [31:0] DMemWData;
  logic [3:0]  DMemWStrb;
  logic        DMemReady;
  logic [31:0] DMemRData;

  modport master (
    output DMemReq, DMemWe, DMemAddr, DMemWData, DMemWStrb,
    input  DMemReady, DMemRData
  );

  modport slave (
    input  DMemReq, DMemWe, DMemAddr, DMemWData, DMemWStrb,
    output DMemReady, DMemRData
  );
endinterface

// File: rtl/dmem_lsu_load_extend.sv
// Load lane select and sign/zero extension of a 32-bit memory read word.
module load_extend
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Memory-stage load/store unit: one request/ready transaction per op, stalling the pipe.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned ops instead of force-aligning them.
module dmem_lsu
  import riscv_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  dmem_if.master      dmem,
  output lsu_state_e  state_dbg
);

  lsu_state_e  state_q, state_d;
  logic        start;
  logic        mem_op;
  logic        trap;
  logic [1:0]  size;
  logic [1:0]  off;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [31:0] ext_data;

  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] read_data_q;

  assign mem_op = MemReadM | MemWriteM;
  assign size   = access_size(Funct3M);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((size == SZ_HALF) && ALUResultM[0]) ||
                      ((size == SZ_WORD) && (ALUResultM[1:0] != 2'b00));
  assign trap      = (state_q == ST_IDLE) && mem_op && misaligned;
  assign MisalignM = trap;
`else
  assign trap      = 1'b0;
  assign MisalignM = 1'b0;
`endif

  // Offset with misaligned low bits dropped; a trapped op never uses it.
  always_comb begin
    off = ALUResultM[1:0];
    if (size == SZ_WORD)      off = 2'b00;
    else if (size == SZ_HALF) off = {ALUResultM[1], 1'b0};
  end

  always_comb begin
    strb  = 4'b1111;
    wdata = WriteDataM;
    case (size)
      SZ_BYTE: begin strb = 4'b0001 << off; wdata = {4{WriteDataM[7:0]}};  end
      SZ_HALF: begin strb = 4'b0011 << off; wdata = {2{WriteDataM[15:0]}}; end
      default: begin strb = 4'b1111;        wdata = WriteDataM;            end
    endcase
    if (!MemWriteM) strb = 4'b0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    StallM  = 1'b0;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && !trap) begin
          StallM  = 1'b1;
          start   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        StallM = 1'b1;
        if (dmem.DMemReady) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  load_extend u_load_extend (
    .rdata  (dmem.DMemRData),
    .addr   (off_q),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      strb_q      <= 4'd0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      read_data_q <= 32'd0;
    end else begin
      if (start) begin
        req_q   <= 1'b1;
        we_q    <= MemWriteM;
        addr_q  <= {ALUResultM[31:2], 2'b00};
        wdata_q <= wdata;
        strb_q  <= strb;
        f3_q    <= Funct3M;
        off_q   <= off;
      end else if (state_q == ST_REQ && dmem.DMemReady) begin
        req_q <= 1'b0;
        if (!we_q) read_data_q <= ext_data;
      end
    end
  end

  assign dmem.DMemReq   = req_q;
  assign dmem.DMemWe    = we_q;
  assign dmem.DMemAddr  = addr_q;
  assign dmem.DMemWData = wdata_q;
  assign dmem.DMemWStrb = strb_q;
  assign ReadDataM      = read_data_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with an expected-ReadDataM queue and a responsive memory.
// Covers both LSU_MISALIGN_TRAP_EN builds.
module tb_dmem_lsu;
  import riscv_mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  lsu_state_e  state_dbg;

  dmem_if dmem ();

  dmem_lsu dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .dmem       (dmem),
    .state_dbg  (state_dbg)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = 32'd0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    Funct3M    = 3'd0;
    ALUResultM = 32'd0;
    WriteDataM = 32'd0;
  endtask

  // One memory op from IDLE through DONE, memory answering after wait_n extra REQ cycles.
  task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input int wait_n, input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rd);
    int          stall_cnt = 0;
    int          req_cnt = 0;
    bit          seen_done = 1'b0;
    logic [31:0] got = 32'd0;
    logic [31:0] exp;
    exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    dmem.DMemReady = 1'b0;
    for (int c = 0; c < wait_n + 8 && !seen_done; c++) begin
      @(negedge clk);
      if (c == 0) chk({tag, " misalign"}, 32'(MisalignM), 32'd0);
      if (StallM) stall_cnt++;
      if (dmem.DMemReq) begin
        chk({tag, " addr"}, dmem.DMemAddr, exp_addr);
        chk({tag, " strb"}, 32'(dmem.DMemWStrb), 32'(exp_strb));
        chk({tag, " we"}, 32'(dmem.DMemWe), 32'(wr));
        if (wr) chk({tag, " wdata"}, dmem.DMemWData, exp_wdata);
      end
      if (state_dbg == ST_DONE) begin
        seen_done = 1'b1;
        got = ReadDataM;
      end
      dmem.DMemReady = dmem.DMemReq && (req_cnt == wait_n);
      dmem.DMemRData = dmem.DMemReady ? rdata : $urandom;
      if (dmem.DMemReq) req_cnt++;
    end
    chk({tag, " done seen"}, 32'(seen_done), 32'd1);
    chk({tag, " stall cycles"}, 32'(stall_cnt), 32'(wait_n + 2));
    exp = exp_q.pop_front();
    chk({tag, " rdata"}, got, exp);
    @(posedge clk); #1;
    idle_inputs();
    dmem.DMemReady = 1'b0;
    @(negedge clk);
    chk({tag, " back idle"}, 32'(state_dbg), 32'(ST_IDLE));
    chk({tag, " no reissue"}, 32'(dmem.DMemReq), 32'd0);
    chk({tag, " rdata hold"}, ReadDataM, exp);
    last_rd = exp;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    int          w;
    int          b;

    idle_inputs();
    dmem.DMemReady = 1'b0;
    dmem.DMemRData = 32'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rst rdata", ReadDataM, 32'd0);
    chk("rst req", 32'(dmem.DMemReq), 32'd0);
    chk("rst we", 32'(dmem.DMemWe), 32'd0);
    chk("rst addr", dmem.DMemAddr, 32'd0);
    chk("rst wdata", dmem.DMemWData, 32'd0);
    chk("rst strb", 32'(dmem.DMemWStrb), 32'd0);
    chk("rst stall", 32'(StallM), 32'd0);
    chk("rst misalign", 32'(MisalignM), 32'd0);

    run_op("lw", 1, 0, F3_LW,  32'h100, 32'h0, 32'hDEADBEEF, 0, 32'h100, 4'b0000, 32'h0, 32'hDEADBEEF);
    run_op("lb", 1, 0, F3_LB,  32'h103, 32'h0, 32'h80AABBCC, 0, 32'h100, 4'b0000, 32'h0, 32'hFFFFFF80);
    run_op("lbu", 1, 0, F3_LBU, 32'h103, 32'h0, 32'h80AABBCC, 1, 32'h100, 4'b0000, 32'h0, 32'h00000080);
    run_op("lh", 1, 0, F3_LH,  32'h102, 32'h0, 32'h80AABBCC, 0, 32'h100, 4'b0000, 32'h0, 32'hFFFF80AA);
    run_op("lhu", 1, 0, F3_LHU, 32'h102, 32'h0, 32'h80AABBCC, 2, 32'h100, 4'b0000, 32'h0, 32'h000080AA);
    run_op("lb0", 1, 0, F3_LB,  32'h100, 32'h0, 32'h80AABBCC, 0, 32'h100, 4'b0000, 32'h0, 32'hFFFFFFCC);
    run_op("lh0", 1, 0, F3_LH,  32'h200, 32'h0, 32'h12347FFF, 0, 32'h200, 4'b0000, 32'h0, 32'h00007FFF);
    run_op("sb", 0, 1, F3_SB,  32'h101, 32'h12345678, 32'h0, 0, 32'h100, 4'b0010, 32'h78787878, last_rd);
    run_op("sh", 0, 1, F3_SH,  32'h102, 32'h12345678, 32'h0, 1, 32'h100, 4'b1100, 32'h56785678, last_rd);
    run_op("sw", 0, 1, F3_SW,  32'h104, 32'h12345678, 32'h0, 0, 32'h104, 4'b1111, 32'h12345678, last_rd);
    run_op("lw wait4", 1, 0, F3_LW, 32'h300, 32'h0, 32'hA5C3_0F1E, 4, 32'h300, 4'b0000, 32'h0, 32'hA5C30F1E);
    run_op("f3 011", 1, 0, 3'b011, 32'h108, 32'h0, 32'h8000_0001, 0, 32'h108, 4'b0000, 32'h0, 32'h80000001);
    run_op("f3 111", 1, 0, 3'b111, 32'h10C, 32'h0, 32'h0000_FF80, 0, 32'h10C, 4'b0000, 32'h0, 32'h0000FF80);

    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      w = $urandom_range(0, 3);
      b = $urandom_range(0, 3);
      a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
      run_op("rand lw", 1, 0, F3_LW, a, 32'h0, d, w, a, 4'b0000, 32'h0, d);
      run_op("rand lbu", 1, 0, F3_LBU, a + 32'(b), 32'h0, d, w, a, 4'b0000, 32'h0, (d >> (8 * b)) & 32'hFF);
    end

    // reset while the request is outstanding
    @(posedge clk); #1;
    MemReadM = 1'b1; Funct3M = F3_LW; ALUResultM = 32'h400;
    dmem.DMemReady = 1'b0;
    @(negedge clk);
    chk("rst-mid stall", 32'(StallM), 32'd1);
    @(posedge clk); #1;
    chk("rst-mid req before", 32'(dmem.DMemReq), 32'd1);
    chk("rst-mid state before", 32'(state_dbg), 32'(ST_REQ));
    #2 reset = 1'b1;
    #1;
    chk("rst-mid req", 32'(dmem.DMemReq), 32'd0);
    chk("rst-mid state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rst-mid rdata", ReadDataM, 32'd0);
    idle_inputs();
    last_rd = 32'd0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst-mid quiet", 32'(dmem.DMemReq), 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
    run_op("pre trap", 1, 0, F3_LW, 32'h500, 32'h0, 32'h0BAD_F00D, 0, 32'h500, 4'b0000, 32'h0, 32'h0BADF00D);
    @(posedge clk); #1;
    MemReadM = 1'b1; Funct3M = F3_LW; ALUResultM = 32'h102;
    @(negedge clk);
    chk("trap lw misalign", 32'(MisalignM), 32'd1);
    chk("trap lw stall", 32'(StallM), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    MemWriteM = 1'b1; Funct3M = F3_SH; ALUResultM = 32'h103; WriteDataM = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("trap lw req", 32'(dmem.DMemReq), 32'd0);
    chk("trap sh misalign", 32'(MisalignM), 32'd1);
    chk("trap sh stall", 32'(StallM), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("trap sh req", 32'(dmem.DMemReq), 32'd0);
    chk("trap sh strb", 32'(dmem.DMemWStrb), 32'd0);
    chk("trap state", 32'(state_dbg), 32'(ST_IDLE));
    chk("trap rdata", ReadDataM, 32'h0BADF00D);
`else
    run_op("mis lw", 1, 0, F3_LW, 32'h102, 32'h0, 32'hCAFEF00D, 0, 32'h100, 4'b0000, 32'h0, 32'hCAFEF00D);
    run_op("mis lh", 1, 0, F3_LH, 32'h101, 32'h0, 32'h1234_8765, 1, 32'h100, 4'b0000, 32'h0, 32'hFFFF8765);
    run_op("mis sh", 0, 1, F3_SH, 32'h103, 32'h0000_ABCD, 32'h0, 0, 32'h100, 4'b1100, 32'hABCDABCD, last_rd);
    run_op("mis sw", 0, 1, F3_SW, 32'h107, 32'h5555_AAAA, 32'h0, 0, 32'h104, 4'b1111, 32'h5555AAAA, last_rd);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit for the Memory Access stage of the five-stage RV32I pipeline. It takes the memory operation latched by the Execute/Memory pipeline register, runs a request/ready handshake with the data memory, and returns an aligned, sign- or zero-extended load value on `ReadDataM`. That value is the word the Memory/WriteBack register captures. While a transaction is outstanding it holds the pipeline with `StallM`.

## Interface
- No parameters; data and address width fixed at 32.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `MemReadM` input 1: current instruction is a load.
- `MemWriteM` input 1: current instruction is a store; never asserted together with `MemReadM`.
- `Funct3M` input 3: access size/sign. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `ALUResultM` input 32: effective byte address.
- `WriteDataM` input 32: store data (rs2).
- `ReadDataM` output 32: extended load result, registered.
- `StallM` output 1: freeze PC, IF/ID, ID/EX and EX/MEM; bubble MEM/WB.
- `MisalignM` output 1: misaligned access flagged; see Configuration.
- `DMemReq` output 1: memory request, registered.
- `DMemWe` output 1: 1 = write.
- `DMemAddr` output 32: word-aligned address, bits [1:0] = 00.
- `DMemWData` output 32: store data replicated into the selected lanes.
- `DMemWStrb` output 4: byte-lane write enables.
- `DMemReady` input 1: memory accepts/completes the request this cycle.
- `DMemRData` input 32: read word, valid when `DMemReady` is high.

## Operation
- FSM states: IDLE, REQ, DONE. State is one-hot or binary; encoding is free.
- IDLE:
  - If `MemReadM|MemWriteM` and the access is not trapped: `StallM`=1, capture address, data, strobe and size into internal registers, go to REQ.
  - Otherwise: `StallM`=0, stay in IDLE.
- REQ:
  - `DMemReq`=1 and `StallM`=1. Address, data and strobes are held stable until `DMemReady`.
  - On `DMemReady`: for a load, extract and extend the value into `ReadDataM`; go to DONE.
  - Wait is unbounded; no timeout.
- DONE: `StallM`=0 for exactly one cycle so the pipeline advances, then go to IDLE unconditionally. The op still visible in this cycle is not reissued.
- Store strobes:
  - SB: `4'b0001 << addr[1:0]`, data `{4{wd[7:0]}}`.
  - SH: `4'b0011 << addr[1:0]`, data `{2{wd[15:0]}}`.
  - SW: `4'b1111`.
  - Loads: strobe 0000.
- Load extraction:
  - Select byte `addr[1:0]` or half `addr[1]`.
  - B and H sign-extend from bit 7 and bit 15 respectively; BU and HU zero-extend.
  - Funct3 011, 110 and 111 are treated as W.
- `ReadDataM` holds its last load value across stores and non-memory instructions.
- A half access is misaligned if `addr[0]`=1. A word access is misaligned if `addr[1:0]`!=00.

## Timing
- Reset values: state IDLE. `ReadDataM`, `DMemReq`, `DMemWe`, `DMemAddr`, `DMemWData` and `DMemWStrb` are all 0. `StallM` and `MisalignM` are 0.
- Reset mid-transaction: `DMemReq` drops immediately (async) and the request is abandoned. The memory must tolerate the withdrawn request.
- Minimum latency is 3 cycles per memory op: IDLE (cycle 0) → REQ with `DMemReady` (cycle 1) → DONE (cycle 2). `ReadDataM` is valid in cycle 2 and is captured by MEM/WB at the end of cycle 2.
- Each wait cycle of `DMemReady` adds 1 cycle.
- `StallM` is combinational from state and the inputs: high in IDLE with a valid op, and high throughout REQ.
- Back-to-back memory ops: the second op is seen in IDLE the cycle after DONE. There is no overlap.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned op in IDLE drives `MisalignM`=1 combinationally for that cycle.
  - No request is issued, no stall is raised, stores are suppressed, and `ReadDataM` is unchanged.
- Undefined:
  - `MisalignM` is tied 0.
  - Misaligned low address bits are ignored: word accesses force [1:0]=00, half accesses force [0]=0. The access then proceeds normally.

## Structure
- Package `riscv_mem_pkg` holds:
  - Funct3 constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`, `F3_SB`, `F3_SH`, `F3_SW`).
  - The LSU state enum.
- Sub-module `load_extend`: combinational lane select plus sign/zero extension. Inputs are rdata, addr[1:0] and funct3; output is 32-bit data.

## Test plan
- LW at 0x100, `DMemRData`=0xDEADBEEF, ready on the first REQ cycle → `StallM` high for 2 cycles, `ReadDataM`=0xDEADBEEF in cycle 2.
- LB at 0x103 with rdata 0x80AABBCC → `ReadDataM`=0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x102 → 0xFFFF80AA.
- SB at 0x101, `WriteDataM`=0x12345678 → `DMemAddr`=0x100, `DMemWStrb`=0010, `DMemWData`=0x78787878, `DMemWe`=1.
- LW with `DMemReady` delayed 4 cycles → `DMemReq` and address held constant; `StallM` high for 6 cycles total; exactly one DONE.
- `reset` pulsed while in REQ → `DMemReq`=0 the same cycle, state IDLE, `ReadDataM`=0.
- LW at 0x102 → with `LSU_MISALIGN_TRAP_EN`: `MisalignM`=1, no `DMemReq`, no stall. Without it: access to 0x100 proceeds normally.
